ram_port_arbiter: RTL
=====================

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter AW, default 8, RAM address width (256 locations).
REQ-002 Parameter DW, default 4, RAM data width.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RSTN  input  1  reset, synchronous, active-low; sampled on rising CLK edge.
REQ-005 C0_REQ / C1_REQ  input  1  client request; held high with fields stable until granted.
REQ-006 C0_WE / C1_WE  input  1  request type: 1 = write, 0 = read.
REQ-007 C0_ADDR / C1_ADDR  input  AW  request address.
REQ-008 C0_WDATA / C1_WDATA  input  DW  write data; ignored for reads.
REQ-009 C0_GNT / C1_GNT  output  1  combinational accept; request consumed at the same rising edge.
REQ-010 C0_RVALID / C1_RVALID  output  1  registered one-cycle pulse: RDATA belongs to this client.
REQ-011 RDATA  output  DW  registered read data shared by both clients.
REQ-012 MEM_ADDRA  output  AW  RAM write address.
REQ-013 MEM_WEA  output  1  RAM write enable.
REQ-014 MEM_DIN  output  DW  RAM write data.
REQ-015 MEM_ADDRB  output  AW  RAM read address, registered inside the RAM.
REQ-016 MEM_DOUT  input  DW  RAM read data, valid the cycle after MEM_ADDRB is sampled.

Function
REQ-017 Two independent arbiters: write port (requests with WE=1) and read port (requests with WE=0).
REQ-018 One write and one read shall be granted in the same cycle when the clients request different types.
REQ-019 Each port arbiter has a 1-bit round-robin pointer naming the priority client.
REQ-020 Contention on a port: grant the pointer client; the other sees GNT=0 and keeps REQ asserted.
REQ-021 After any grant to client k on a port, that port's pointer becomes 1-k at the clock edge; with no grant, the pointer holds.
REQ-022 At most one GNT per port per cycle; a GNT never asserts while its REQ is low.
REQ-023 Write grant drives MEM_WEA=1, MEM_ADDRA=ADDR and MEM_DIN=WDATA of the winner in the same cycle; otherwise MEM_WEA=0.
REQ-024 Read grant drives MEM_ADDRB=ADDR of the winner in the same cycle; otherwise MEM_ADDRB holds its last driven value.
REQ-025 Read latency: granted in cycle N, so MEM_DOUT is valid in N+1; RDATA is registered from MEM_DOUT and the winner's RVALID pulses in N+2.
REQ-026 A two-stage owner/valid pipeline tracks reads and sustains back-to-back reads, one per cycle, with RVALID order equal to grant order.
REQ-027 RDATA holds its value when no RVALID is asserted.
REQ-028 Same-address read and write granted in the same cycle: the read returns the newly written data (write-first).
REQ-029 A client may issue a new request in the cycle after its grant; throughput is one grant per client per cycle.

Reset
REQ-030 While RSTN=0 at a rising edge: both pointers set to client 0, read pipeline valid bits cleared, RDATA=0, MEM_ADDRB register=0.
REQ-031 While RSTN=0: C0_GNT=C1_GNT=0, MEM_WEA=0, C0_RVALID=C1_RVALID=0, regardless of requests.
REQ-032 Reads in flight when reset asserts are discarded; no RVALID after reset release for pre-reset grants.
REQ-033 First cycle after release: requests are arbitrated normally, with client 0 priority on both ports.

Verification
REQ-034 Sole write: C0 writes ADDR=0x12, WDATA=0xA -> C0_GNT=1 same cycle, MEM_WEA=1, MEM_ADDRA=0x12, MEM_DIN=0xA.
REQ-035 Read-back: C1 reads 0x12 in cycle N -> C1_RVALID=1, RDATA=0xA in N+2, and C0_RVALID=0 throughout.
REQ-036 Write contention after reset: both clients hold writes for 4 cycles -> grants alternate C0,C1,C0,C1 and no cycle has two GNTs.
REQ-037 Mixed traffic: C0 writes 0x05<-0x3 while C1 reads 0x05 in the same cycle -> both granted, and C1 receives 0x3 two cycles later.
REQ-038 Back-to-back reads: C0 reads 0x01, 0x02, 0x03 in consecutive cycles -> three consecutive C0_RVALID pulses carrying matching data.
REQ-039 Reset mid-read: read granted in N, RSTN=0 at edge N+1 -> no RVALID in N+2, all outputs at reset values, pointers at client 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Two-client arbiter in front of a simple dual-port RAM (port A write, port B registered read).
// Writes and reads are arbitrated independently, each with its own round-robin pointer.
module ram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 4
) (
    input  logic          CLK,
    input  logic          RSTN,
    input  logic          C0_REQ,
    input  logic          C0_WE,
    input  logic [AW-1:0] C0_ADDR,
    input  logic [DW-1:0] C0_WDATA,
    input  logic          C1_REQ,
    input  logic          C1_WE,
    input  logic [AW-1:0] C1_ADDR,
    input  logic [DW-1:0] C1_WDATA,
    output logic          C0_GNT,
    output logic          C1_GNT,
    output logic          C0_RVALID,
    output logic          C1_RVALID,
    output logic [DW-1:0] RDATA,
    output logic [AW-1:0] MEM_ADDRA,
    output logic          MEM_WEA,
    output logic [DW-1:0] MEM_DIN,
    output logic [AW-1:0] MEM_ADDRB,
    input  logic [DW-1:0] MEM_DOUT
);

    logic          wptr_q, wptr_d;
    logic          rptr_q, rptr_d;
    logic          v1_q, v1_d, own1_q, own1_d;
    logic          v2_q, v2_d, own2_q, own2_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] addrb_q, addrb_d;

    logic wreq0, wreq1, rreq0, rreq1;
    logic wg0, wg1, rg0, rg1;

    // Requests are masked while in reset so no grant can leak out.
    assign wreq0 = RSTN & C0_REQ &  C0_WE;
    assign wreq1 = RSTN & C1_REQ &  C1_WE;
    assign rreq0 = RSTN & C0_REQ & ~C0_WE;
    assign rreq1 = RSTN & C1_REQ & ~C1_WE;

    assign wg0 = wreq0 & (~wreq1 | ~wptr_q);
    assign wg1 = wreq1 & (~wreq0 |  wptr_q);
    assign rg0 = rreq0 & (~rreq1 | ~rptr_q);
    assign rg1 = rreq1 & (~rreq0 |  rptr_q);

    assign C0_GNT = wg0 | rg0;
    assign C1_GNT = wg1 | rg1;

    assign MEM_WEA   = wg0 | wg1;
    assign MEM_ADDRA = wg1 ? C1_ADDR  : C0_ADDR;
    assign MEM_DIN   = wg1 ? C1_WDATA : C0_WDATA;
    assign MEM_ADDRB = addrb_d;

    assign C0_RVALID = RSTN & v2_q & ~own2_q;
    assign C1_RVALID = RSTN & v2_q &  own2_q;
    assign RDATA     = rdata_q;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        addrb_d = addrb_q;
        if (wg0) wptr_d = 1'b1;
        else if (wg1) wptr_d = 1'b0;
        if (rg0) begin
            rptr_d  = 1'b1;
            addrb_d = C0_ADDR;
        end else if (rg1) begin
            rptr_d  = 1'b0;
            addrb_d = C1_ADDR;
        end
        // Stage 1 marks the cycle MEM_DOUT is valid; stage 2 presents RDATA.
        v1_d    = rg0 | rg1;
        own1_d  = rg1;
        v2_d    = v1_q;
        own2_d  = own1_q;
        rdata_d = v1_q ? MEM_DOUT : rdata_q;
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            v1_q    <= 1'b0;
            own1_q  <= 1'b0;
            v2_q    <= 1'b0;
            own2_q  <= 1'b0;
            rdata_q <= '0;
            addrb_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            v1_q    <= v1_d;
            own1_q  <= own1_d;
            v2_q    <= v2_d;
            own2_q  <= own2_d;
            rdata_q <= rdata_d;
            addrb_q <= addrb_d;
        end
    end

endmodule
